timer_counter: RTL

Memory-mapped down-counting timer: the responder on the system bridge's peripheral bus. It accepts register writes and reads addressed by the bridge, counts down from a programmed preset, and raises an interrupt request that the bridge forwards into the CPU's hardware-interrupt vector. Two instances sit behind the bridge, as timer 1 and timer 2.

---
 rtl/timer_counter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/timer_counter.sv
// timer_counter: 32-bit memory-mapped down-counting timer with interrupt.
// Register map on addr[3:2]: 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET, 2 COUNT (RO), 3 reserved.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  state_t      state, state_nxt;
  logic        en, im, irqf;
  logic [1:0]  mode;
  logic [31:0] preset, count;

  // FSM-issued datapath controls
  logic cnt_load, cnt_dec, cnt_zero, irqf_set, irqf_clr, en_clr;

  logic wr_ctrl, wr_preset, auto_rld;
  logic unused_addr;

  assign wr_ctrl     = we && (addr[3:2] == A_CTRL);
  assign wr_preset   = we && (addr[3:2] == A_PRESET);
  // Only MODE=01 reloads; 10 and 11 fall back to one-shot.
  assign auto_rld    = (mode == 2'b01);
  assign unused_addr = ^{addr[31:4], addr[1:0], wdata[31:4]};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; COUNT of 0 or 1 both finish in a single CNT cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = LOAD;
      LOAD:    state_nxt = CNT;
      CNT:     if (!en) state_nxt = IDLE;
               else if (count <= 32'd1) state_nxt = INT;
      INT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output decode into datapath strobes
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_zero = 1'b0;
    irqf_set = 1'b0;
    irqf_clr = 1'b0;
    en_clr   = 1'b0;
    case (state)
      LOAD: cnt_load = 1'b1;
      CNT: if (en) begin
        if (count > 32'd1) cnt_dec = 1'b1;
        else begin
          cnt_zero = 1'b1;
          irqf_set = 1'b1;
        end
      end
      INT: if (auto_rld) irqf_clr = 1'b1;
           else          en_clr   = 1'b1;
      default: ;
    endcase
  end

  // CTRL: a software write beats the one-shot EN clear on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en   <= 1'b0;
      mode <= 2'b00;
      im   <= 1'b0;
    end else if (wr_ctrl) begin
      en   <= wdata[0];
      mode <= wdata[2:1];
      im   <= wdata[3];
    end else if (en_clr) begin
      en   <= 1'b0;
    end
  end

  // PRESET: only sampled into COUNT on LOAD, so mid-count writes wait for the next run
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         preset <= '0;
    else if (wr_preset) preset <= wdata;
  end

  // COUNT: load, decrement, or pin to zero; never wraps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        count <= '0;
    else if (cnt_load) count <= preset;
    else if (cnt_dec)  count <= count - 32'd1;
    else if (cnt_zero) count <= '0;
  end

  // IRQF: expiry set wins over a same-edge software clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                irqf <= 1'b0;
    else if (irqf_set)                         irqf <= 1'b1;
    else if (irqf_clr || wr_ctrl || wr_preset) irqf <= 1'b0;
  end

  assign irq = irqf & im;

  // Read mux, combinational on addr only
  always_comb begin
    rdata = '0;
    case (addr[3:2])
      A_CTRL:   rdata = {28'd0, im, mode, en};
      A_PRESET: rdata = preset;
      A_COUNT:  rdata = count;
      default:  rdata = '0;
    endcase
  end

endmodule
